mem_access_unit: RTL and testbench

- Memory-interface stage directly downstream of the multi-cycle CPU controller.
- Consumes the controller's mem_read / mem_write / i_or_d / ir_write strobes, selects the PC or ALU-out address, and runs a wait-state access to an external synchronous unified memory.
- Captures read data into the instruction register (IR) or memory data register (MDR).
- Raises stall so the controller and datapath hold their state until the access completes.

---
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access stage: selects pc/alu_out address, runs a wait-state access, captures read data into ir or mdr.
// Latency: stall is high for WAIT_CYCLES+2 cycles per request; new ir/mdr is visible from the DONE cycle.
// Backpressure: stall holds the controller; requests seen in ACCESS or DONE are ignored, not queued.
module mem_access_unit #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              i_or_d,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              conflict
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Counter is 4 bits wide: WAIT_CYCLES is limited to 0..15.
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              is_wr_q, is_wr_d;
    logic              dest_ir_q, dest_ir_d;
    logic              conflict_q, conflict_d;

    // Next-state, request capture, read-data capture and stall generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        is_wr_d    = is_wr_q;
        dest_ir_d  = dest_ir_q;
        conflict_d = conflict_q;
        stall      = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = mem_read | mem_write;
                if (mem_read | mem_write) begin
                    addr_d    = i_or_d ? alu_out : pc;
                    wdata_d   = wdata;
                    // A write always wins over a simultaneous read.
                    is_wr_d   = mem_write;
                    dest_ir_d = ir_write;
                    cnt_d     = WAIT_LD;
                    state_d   = ACCESS;
                    if (mem_read & mem_write) begin
                        conflict_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!is_wr_q) begin
                        if (dest_ir_q) begin
                            ir_d = mem_rdata;
                        end else begin
                            mdr_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // The controller still presents the finished request here; ignore it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ir_q       <= '0;
            mdr_q      <= '0;
            is_wr_q    <= 1'b0;
            dest_ir_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ir_q       <= ir_d;
            mdr_q      <= mdr_d;
            is_wr_q    <= is_wr_d;
            dest_ir_q  <= dest_ir_d;
            conflict_q <= conflict_d;
        end
    end

    // Strobes decode straight from the state flop so reset drops them at once.
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & is_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of directed transactions plus hand-written reset and back-to-back sequences.
// Two instances: WAIT_CYCLES=2 (main) and WAIT_CYCLES=0, sharing the same input stimulus.
// Outputs are sampled 1 time unit after the falling edge; inputs change on the falling edge.
module tb_mem_access_unit;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int W  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write, i_or_d, ir_write;
    logic [AW-1:0] pc, alu_out;
    logic [DW-1:0] wdata, mem_rdata;

    logic [AW-1:0] mem_addr, w0_mem_addr;
    logic [DW-1:0] mem_wdata, w0_mem_wdata;
    logic          mem_en, mem_we, stall, conflict;
    logic          w0_mem_en, w0_mem_we, w0_stall, w0_conflict;
    logic [DW-1:0] ir, mdr, w0_ir, w0_mdr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc(pc), .alu_out(alu_out),
        .wdata(wdata), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we), .ir(ir),
        .mdr(mdr), .stall(stall), .conflict(conflict)
    );

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc(pc), .alu_out(alu_out),
        .wdata(wdata), .mem_rdata(mem_rdata), .mem_addr(w0_mem_addr),
        .mem_wdata(w0_mem_wdata), .mem_en(w0_mem_en), .mem_we(w0_mem_we), .ir(w0_ir),
        .mdr(w0_mdr), .stall(w0_stall), .conflict(w0_conflict)
    );

    typedef struct {
        logic          rd, wr, iod, irw;
        logic [AW-1:0] pc, alu;
        logic [DW-1:0] wd, rdat;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_ir, e_mdr;
        logic          e_conf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_or_d    = 1'b0;
        ir_write  = 1'b0;
        pc        = '0;
        alu_out   = '0;
        wdata     = '0;
        mem_rdata = '0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one transaction on the WAIT_CYCLES=2 instance and checks the whole access.
    task automatic run_vec(input vec_t v, input string tag);
        int   st_n, en_n;
        logic addr_ok, we_ok, wd_ok;
        @(negedge clk);
        mem_read  = v.rd;
        mem_write = v.wr;
        i_or_d    = v.iod;
        ir_write  = v.irw;
        pc        = v.pc;
        alu_out   = v.alu;
        wdata     = v.wd;
        mem_rdata = v.rdat;
        #1;
        st_n = 0; en_n = 0; addr_ok = 1'b1; we_ok = 1'b1; wd_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!stall) break;
            st_n++;
            if (mem_en) begin
                en_n++;
                if (mem_addr !== v.e_addr) addr_ok = 1'b0;
                if (mem_we !== v.e_we) we_ok = 1'b0;
                if (v.e_we && mem_wdata !== v.wd) wd_ok = 1'b0;
            end
            @(negedge clk);
            // Scramble the address/data/destination inputs mid-access; they must be ignored.
            if (c == 1) begin
                pc       = ~v.pc;
                alu_out  = ~v.alu;
                wdata    = ~v.wd;
                i_or_d   = ~v.iod;
                ir_write = ~v.irw;
            end
            #1;
        end
        chk({tag, " stall_cycles"}, st_n, W + 2);
        chk({tag, " en_cycles"}, en_n, W + 1);
        chk({tag, " addr_ok"}, addr_ok, 1);
        chk({tag, " we_ok"}, we_ok, 1);
        chk({tag, " wdata_ok"}, wd_ok, 1);
        chk({tag, " done_en"}, {mem_en, mem_we}, 0);
        chk({tag, " ir"}, ir, v.e_ir);
        chk({tag, " mdr"}, mdr, v.e_mdr);
        chk({tag, " conflict"}, conflict, v.e_conf);
        idle_inputs();
    endtask

    initial begin
        logic [5:0] st_pat, en_pat;
        vec_t       v;

        //          rd    wr    iod   irw   pc       alu      wd        rdat      e_addr   e_we  e_ir      e_mdr     e_conf
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h010, 12'h777, 16'h0000, 16'hC123, 12'h010, 1'b0, 16'hC123, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'h001, 12'h3FF, 16'h0000, 16'hBEEF, 12'h3FF, 1'b0, 16'hC123, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h002, 12'h020, 16'h5A5A, 16'h1111, 12'h020, 1'b1, 16'hC123, 16'hBEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h155, 12'h0AA, 16'h0F0F, 16'h2222, 12'h155, 1'b1, 16'hC123, 16'hBEEF, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'hABC, 12'h123, 16'h0000, 16'h7777, 12'hABC, 1'b0, 16'h7777, 16'hBEEF, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'h001, 12'hFFF, 16'h0000, 16'h0042, 12'hFFF, 1'b0, 16'h7777, 16'h0042, 1'b1};

        // Reset state, with a request present to show stall is forced low.
        idle_inputs();
        rst      = 1'b1;
        mem_read = 1'b1;
        #3;
        chk("rst stall", stall, 0);
        chk("rst outs", {mem_en, mem_we, conflict}, 0);
        chk("rst addr", mem_addr, 0);
        chk("rst wdata", mem_wdata, 0);
        chk("rst ir_mdr", {ir, mdr}, 0);
        @(negedge clk);
        mem_read = 1'b0;
        rst      = 1'b0;
        #1;
        chk("idle stall", stall, 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Sticky conflict survives an idle cycle and clears only on reset.
        @(negedge clk);
        #1;
        chk("conflict sticky", conflict, 1);
        pulse_rst();
        #1;
        chk("conflict cleared", conflict, 0);

        // WAIT_CYCLES=0: read held high continuously gives stall 1,1,0,1,1,0.
        @(negedge clk);
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc        = 12'h123;
        mem_rdata = 16'h3C3C;
        #1;
        st_pat[5] = w0_stall;
        en_pat[5] = w0_mem_en;
        for (int k = 4; k >= 0; k--) begin
            @(negedge clk);
            #1;
            st_pat[k] = w0_stall;
            en_pat[k] = w0_mem_en;
        end
        chk("w0 stall pattern", st_pat, 6'b110110);
        chk("w0 en pattern", en_pat, 6'b010010);
        chk("w0 addr", w0_mem_addr, 12'h123);
        chk("w0 ir", w0_ir, 16'h3C3C);
        chk("w0 mdr", w0_mdr, 16'h0000);
        pulse_rst();

        // Reset asserted in the second ACCESS cycle of a fetch.
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h0AA, 12'h000, 16'h0000, 16'h9999, 12'h0AA, 1'b0, 16'h9999, 16'h0000, 1'b0};
        run_vec(v, "pre_fetch");
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 12'h0BB, 16'h0000, 16'h1234, 12'h0BB, 1'b0, 16'h9999, 16'h1234, 1'b0};
        run_vec(v, "pre_load");
        @(negedge clk);
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc        = 12'h0CC;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid en before rst", mem_en, 1);
        rst = 1'b1;
        #1;
        chk("mid rst en", {mem_en, mem_we}, 0);
        chk("mid rst stall", stall, 0);
        chk("mid rst ir", ir, 0);
        chk("mid rst mdr", mdr, 0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post rst idle", {stall, mem_en}, 0);
        chk("post rst ir", ir, 0);
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h0DD, 12'h000, 16'h0000, 16'h4321, 12'h0DD, 1'b0, 16'h4321, 16'h0000, 1'b0};
        run_vec(v, "post_rst_fetch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
